// File: rtl/spi_slave_port.sv
// Mode-0 SPI slave sampled in the fabric clock domain: deserialises MOSI words, serialises TX words on MISO.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first on both RX and TX (default MSB first).
module spi_slave_port #(
   parameter int                DATA_W      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
   input  logic              i_fab_clk,
   input  logic              i_mss_reset_n,
   input  logic              i_spi_sclk,
   input  logic              i_spi_ss_n,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output logic              o_spi_miso_oe,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_load,
   output logic              o_tx_ready,
   input  logic              i_clr_flags,
   output logic              o_tx_underrun,
   output logic              o_frame_err,
   output logic              o_frame_active
);

   localparam int         CNT_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;
`ifdef SPI_SLAVE_LSB_FIRST_EN
   localparam int         TX_FIRST  = 0;
`else
   localparam int         TX_FIRST  = DATA_W - 1;
`endif

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
   logic                   r_sclk_d, r_ss_d;
   logic [0:0]             r_state;
   logic [CNT_W-1:0]       r_bit_cnt;
   logic [DATA_W-1:0]      r_rx_shift, r_tx_shift, r_hold, r_rx_data;
   logic                   r_hold_full, r_reload_pend, r_rx_valid;
   logic                   r_miso, r_miso_oe, r_tx_underrun, r_frame_err;

   logic                   w_sclk_s, w_ss_s, w_mosi_s;
   logic                   w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
   logic                   w_load, w_last_bit;
   logic [DATA_W-1:0]      w_tx_word, w_tx_shifted, w_rx_next;

   always_ff @(posedge i_fab_clk or negedge i_mss_reset_n) begin
      if (!i_mss_reset_n) begin
         r_sclk_sync <= '0;
         r_ss_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_ss_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_spi_ss_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         r_sclk_d    <= w_sclk_s;
         r_ss_d      <= w_ss_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_ss_fall   = ~w_ss_s & r_ss_d;
   assign w_ss_rise   = w_ss_s & ~r_ss_d;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign w_rx_next    = {w_mosi_s, r_rx_shift[DATA_W-1:1]};
   assign w_tx_shifted = {1'b0, r_tx_shift[DATA_W-1:1]};
`else
   assign w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi_s};
   assign w_tx_shifted = {r_tx_shift[DATA_W-2:0], 1'b0};
`endif

   assign w_tx_word  = r_hold_full ? r_hold : IDLE_BYTE;
   assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_W - 1));
   // Shifter loads at frame start and on the first SCLK fall after each completed word.
   assign w_load     = ((r_state == ST_IDLE) && w_ss_fall) ||
                       ((r_state == ST_ACTIVE) && !w_ss_rise && w_sclk_fall && r_reload_pend);

   always_ff @(posedge i_fab_clk or negedge i_mss_reset_n) begin
      if (!i_mss_reset_n) begin
         r_state       <= ST_IDLE;
         r_bit_cnt     <= '0;
         r_rx_shift    <= '0;
         r_tx_shift    <= '0;
         r_hold        <= '0;
         r_hold_full   <= 1'b0;
         r_reload_pend <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_miso        <= 1'b1;
         r_miso_oe     <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (i_clr_flags) begin
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
         end
         if (w_load) begin
            r_tx_shift  <= w_tx_word;
            r_miso      <= w_tx_word[TX_FIRST];
            r_hold_full <= 1'b0;
            if (!r_hold_full)
               r_tx_underrun <= 1'b1;
         end
         // Accepted only when empty, so it never collides with the shifter draining a full register.
         if (i_tx_load && !r_hold_full) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_ss_fall) begin
                  r_state       <= ST_ACTIVE;
                  r_miso_oe     <= 1'b1;
                  r_bit_cnt     <= '0;
                  r_reload_pend <= 1'b0;
               end
            end
            default: begin
               if (w_ss_rise) begin
                  r_state       <= ST_IDLE;
                  r_miso_oe     <= 1'b0;
                  r_miso        <= 1'b1;
                  r_bit_cnt     <= '0;
                  r_reload_pend <= 1'b0;
                  if (r_bit_cnt != '0)
                     r_frame_err <= 1'b1;
               end else if (w_sclk_rise) begin
                  r_rx_shift <= w_rx_next;
                  if (w_last_bit) begin
                     r_rx_data     <= w_rx_next;
                     r_rx_valid    <= 1'b1;
                     r_bit_cnt     <= '0;
                     r_reload_pend <= 1'b1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else if (w_sclk_fall) begin
                  if (r_reload_pend) begin
                     r_reload_pend <= 1'b0;
                  end else begin
                     r_tx_shift <= w_tx_shifted;
                     r_miso     <= w_tx_shifted[TX_FIRST];
                  end
               end
            end
         endcase
      end
   end

   assign o_spi_miso     = r_miso;
   assign o_spi_miso_oe  = r_miso_oe;
   assign o_rx_data      = r_rx_data;
   assign o_rx_valid     = r_rx_valid;
   assign o_tx_ready     = ~r_hold_full;
   assign o_tx_underrun  = r_tx_underrun;
   assign o_frame_err    = r_frame_err;
   assign o_frame_active = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: bit-banged mode-0 master, RX scoreboard queue checked on RX_VALID.
module tb_spi_slave_port;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_sclk = 1'b0;
   logic       spi_ss_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       o_spi_miso, o_spi_miso_oe, o_rx_valid, o_tx_ready;
   logic       o_tx_underrun, o_frame_err, o_frame_active;
   logic [7:0] o_rx_data;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       clr_flags = 1'b0;

   int         n_checks = 0;
   int         n_fail = 0;
   int         rx_seen = 0;
   int         rx_before;
   logic       prev_valid = 1'b0;
   logic [7:0] rx_exp_q[$];
   logic [7:0] rd;

   always #5 clk = ~clk;

   spi_slave_port dut (
      .i_fab_clk      (clk),
      .i_mss_reset_n  (rst_n),
      .i_spi_sclk     (spi_sclk),
      .i_spi_ss_n     (spi_ss_n),
      .i_spi_mosi     (spi_mosi),
      .o_spi_miso     (o_spi_miso),
      .o_spi_miso_oe  (o_spi_miso_oe),
      .o_rx_data      (o_rx_data),
      .o_rx_valid     (o_rx_valid),
      .i_tx_data      (tx_data),
      .i_tx_load      (tx_load),
      .o_tx_ready     (o_tx_ready),
      .i_clr_flags    (clr_flags),
      .o_tx_underrun  (o_tx_underrun),
      .o_frame_err    (o_frame_err),
      .o_frame_active (o_frame_active)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RX scoreboard: every RX_VALID pops one expected word; pulse must last one cycle.
   always @(negedge clk) begin
      if (rst_n && o_rx_valid) begin
         check("rx_valid_width", {31'd0, prev_valid}, 32'd0);
         if (rx_exp_q.size() == 0)
            check("rx_unexpected", 32'd1, 32'd0);
         else
            check("rx_data", {24'd0, o_rx_data}, {24'd0, rx_exp_q.pop_front()});
         rx_seen++;
         $display("rx   data=%02h t=%0t", o_rx_data, $time);
      end
      prev_valid <= o_rx_valid;
   end

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = tx[7-i];
         repeat (4) @(negedge clk);
         rx[7-i] = o_spi_miso;
         spi_sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi_sclk = 1'b0;
      end
      $display("xfer mosi=%02h miso=%02h bits=%0d", tx, rx, nbits);
   endtask

   task automatic byte_xfer(input logic [7:0] tx, input logic [7:0] exp_miso, input string tag);
      logic [7:0] r;
      rx_exp_q.push_back(tx);
      spi_xfer(tx, 8, r);
      check(tag, {24'd0, r}, {24'd0, exp_miso});
   endtask

   task automatic frame_begin();
      @(negedge clk);
      spi_ss_n = 1'b0;
   endtask

   task automatic frame_end();
      repeat (4) @(negedge clk);
      spi_ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic clear_flags();
      @(negedge clk);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, o_spi_miso}, 32'd1);
      check("rst_oe", {31'd0, o_spi_miso_oe}, 32'd0);
      check("rst_rx_data", {24'd0, o_rx_data}, 32'd0);
      check("rst_tx_ready", {31'd0, o_tx_ready}, 32'd1);
      check("rst_flags", {30'd0, o_tx_underrun, o_frame_err}, 32'd0);
      check("rst_active", {31'd0, o_frame_active}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte with a preloaded word
      load_tx(8'hA5);
      check("t2_ready_low", {31'd0, o_tx_ready}, 32'd0);
      rx_before = rx_seen;
      frame_begin();
      byte_xfer(8'h3C, 8'hA5, "t2_miso");
      check("t2_oe_in_frame", {30'd0, o_spi_miso_oe, o_frame_active}, 32'd3);
      frame_end();
      check("t2_ready_high", {31'd0, o_tx_ready}, 32'd1);
      check("t2_rx_count", rx_seen - rx_before, 32'd1);
      check("t2_rx_data", {24'd0, o_rx_data}, 32'h3C);
      check("t2_idle_pins", {30'd0, o_spi_miso_oe, o_spi_miso}, 32'd1);
      check("t2_inactive", {31'd0, o_frame_active}, 32'd0);

      // Three-byte frame, one word loaded
      clear_flags();
      check("t3_underrun_clr", {31'd0, o_tx_underrun}, 32'd0);
      load_tx(8'h11);
      rx_before = rx_seen;
      frame_begin();
      byte_xfer(8'h01, 8'h11, "t3_miso0");
      byte_xfer(8'h02, 8'hFF, "t3_miso1");
      byte_xfer(8'h03, 8'hFF, "t3_miso2");
      frame_end();
      check("t3_rx_count", rx_seen - rx_before, 32'd3);
      check("t3_underrun", {31'd0, o_tx_underrun}, 32'd1);

      // Aborted word after 5 bits
      clear_flags();
      rx_before = rx_seen;
      frame_begin();
      spi_xfer(8'hE7, 5, rd);
      frame_end();
      check("t4_no_valid", rx_seen - rx_before, 32'd0);
      check("t4_frame_err", {31'd0, o_frame_err}, 32'd1);
      check("t4_rx_kept", {24'd0, o_rx_data}, 32'h03);
      clear_flags();
      check("t4_err_clr", {31'd0, o_frame_err}, 32'd0);
      frame_begin();
      byte_xfer(8'hC6, 8'hFF, "t4_miso");
      frame_end();
      check("t4_rx_count", rx_seen - rx_before, 32'd1);
      check("t4_rx_data", {24'd0, o_rx_data}, 32'hC6);

      // TX_LOAD in the exact cycle the shifter loads from an empty holding register
      clear_flags();
      check("t5_ready_pre", {31'd0, o_tx_ready}, 32'd1);
      @(negedge clk);
      spi_ss_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tx_data = 8'h77;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      check("t5_ready_held", {31'd0, o_tx_ready}, 32'd0);
      check("t5_underrun", {31'd0, o_tx_underrun}, 32'd1);
      byte_xfer(8'h5A, 8'hFF, "t5_miso0");
      byte_xfer(8'h96, 8'h77, "t5_miso1");
      frame_end();
      check("t5_ready_post", {31'd0, o_tx_ready}, 32'd1);

      // Load while holding is full is dropped
      load_tx(8'h55);
      check("t6_ready_low", {31'd0, o_tx_ready}, 32'd0);
      load_tx(8'hAA);
      frame_begin();
      byte_xfer(8'hE1, 8'h55, "t6_miso");
      frame_end();
      check("t6_ready_high", {31'd0, o_tx_ready}, 32'd1);
      frame_begin();
      byte_xfer(8'h1E, 8'hFF, "t6_dropped");
      frame_end();

      // Asynchronous reset in the middle of a frame
      frame_begin();
      spi_xfer(8'hF0, 3, rd);
      load_tx(8'h12);
      check("t1_active", {31'd0, o_frame_active}, 32'd1);
      check("t1_ready_low", {31'd0, o_tx_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_oe", {31'd0, o_spi_miso_oe}, 32'd0);
      check("t1_miso", {31'd0, o_spi_miso}, 32'd1);
      check("t1_active_clr", {31'd0, o_frame_active}, 32'd0);
      check("t1_ready", {31'd0, o_tx_ready}, 32'd1);
      check("t1_rx_data", {24'd0, o_rx_data}, 32'd0);
      check("t1_flags", {29'd0, o_rx_valid, o_tx_underrun, o_frame_err}, 32'd0);
      @(negedge clk);
      spi_ss_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      check("rx_queue_empty", rx_exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
